// File: rtl/leros_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : leros_run_ctrl
//  Purpose  : Wishbone-controlled run sequencer for the LerosFsmd core. Holds
//             the core in reset, releases it on START, runs a watchdog,
//             captures io_dout on exit and reports DONE/TIMEOUT via irq_o.
//  Options  : LEROS_CYCLE_CNT_EN adds the CYCLES register at offset 0x10.
//  Revision : 1.0 - initial release
// ============================================================================
module leros_run_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          TIMEOUT_W  = 24,
  parameter int          RST_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_rst_o,
  input  logic [31:0] core_dout_i,
  input  logic        core_exit_i,
  output logic        irq_o
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] c_RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [RCW-1:0]         rcnt_q;
  logic [TIMEOUT_W-1:0]   timer_q;
  logic [TIMEOUT_W-1:0]   limit_q;
  logic [31:0]            result_q;
  logic                   done_q, timeout_q, irq_en_q, irq_q, core_rst_q;
  logic                   ack_q;
  logic [31:0]            dat_q;

  // Bus decode: a request is a hit that is not already being acked
  logic        w_hit, w_req, w_wr, w_map;
  logic [2:0]  w_off;
  logic        w_ctrl_wr, w_stat_wr, w_lim_wr;
  logic        w_start, w_abort, w_start_acc, w_tmo;
  logic [31:0] w_lim_ext, w_lim_merge, w_cycles_rd;
  logic [31:0] w_rdata;

  assign w_hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_req       = w_hit & ~ack_q;
  assign w_wr        = w_req & wbs_we_i;
  assign w_off       = wbs_adr_i[4:2];
  assign w_map       = (wbs_adr_i[7:5] == 3'd0);
  assign w_ctrl_wr   = w_wr & w_map & (w_off == 3'd0) & wbs_sel_i[0];
  assign w_stat_wr   = w_wr & w_map & (w_off == 3'd1) & wbs_sel_i[0];
  assign w_lim_wr    = w_wr & w_map & (w_off == 3'd2);
  assign w_start     = w_ctrl_wr & wbs_dat_i[0];
  assign w_abort     = w_ctrl_wr & wbs_dat_i[1];
  assign w_start_acc = w_start & ~w_abort & ((state_q == S_IDLE) | (state_q == S_HALT));
  assign w_tmo       = (limit_q != '0) & (timer_q == (limit_q - TIMEOUT_W'(1)));

  // Byte-lane merge of LIMIT writes; only the low TIMEOUT_W bits are kept
  assign w_lim_ext = 32'(limit_q);
  for (genvar b = 0; b < 4; b++) begin : g_lim_byte
    assign w_lim_merge[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : w_lim_ext[8*b +: 8];
  end

  wire w_unused = &{1'b0, wbs_adr_i[1:0], w_lim_merge};

`ifdef LEROS_CYCLE_CNT_EN
  logic [31:0] run_cnt_q, cycles_q;
  logic [31:0] w_run_cnt_inc;
  logic        w_halt_enter;

  assign w_run_cnt_inc = (run_cnt_q == 32'hFFFF_FFFF) ? run_cnt_q : run_cnt_q + 32'd1;
  assign w_halt_enter  = (state_q == S_RUN) & ~w_abort & (core_exit_i | w_tmo);
  assign w_cycles_rd   = cycles_q;

  // Run-length counter, latched into CYCLES on entry to HALT
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      run_cnt_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else if (w_start_acc) begin
      run_cnt_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else if ((state_q == S_RUN) && !w_abort) begin
      run_cnt_q <= w_run_cnt_inc;
      if (w_halt_enter) cycles_q <= w_run_cnt_inc;
    end
  end
`else
  assign w_cycles_rd = 32'd0;
`endif

  // Register read mux; unmapped offsets return zero
  always_comb begin
    w_rdata = 32'd0;
    if (w_map) begin
      case (w_off)
        3'd0:    w_rdata = {29'd0, irq_en_q, 2'b00};
        3'd1:    w_rdata = {28'd0, timeout_q, done_q, state_q};
        3'd2:    w_rdata = w_lim_ext;
        3'd3:    w_rdata = result_q;
        3'd4:    w_rdata = w_cycles_rd;
        default: w_rdata = 32'd0;
      endcase
    end
  end

  // Single-cycle ack with registered read data held between accesses
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
      ack_q <= w_req;
      if (w_req) dat_q <= w_rdata;
    end
  end

  // Software-owned configuration: IRQ enable and watchdog limit
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en_q <= 1'b0;
      limit_q  <= '0;
    end else begin
      if (w_ctrl_wr) irq_en_q <= wbs_dat_i[2];
      if (w_lim_wr)  limit_q  <= w_lim_merge[TIMEOUT_W-1:0];
    end
  end

  // Run sequencer: state, reset hold, watchdog, status flags and result
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      rcnt_q     <= '0;
      timer_q    <= '0;
      result_q   <= 32'd0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      // W1C first so that a same-cycle set below wins
      if (w_stat_wr && wbs_dat_i[2]) done_q    <= 1'b0;
      if (w_stat_wr && wbs_dat_i[3]) timeout_q <= 1'b0;
      if (w_abort) begin
        state_q    <= S_IDLE;
        core_rst_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE, S_HALT: begin
            if (w_start) begin
              state_q    <= S_RESET;
              rcnt_q     <= '0;
              timer_q    <= '0;
              done_q     <= 1'b0;
              timeout_q  <= 1'b0;
              core_rst_q <= 1'b1;
            end
          end
          S_RESET: begin
            if (rcnt_q == c_RST_LAST) begin
              state_q    <= S_RUN;
              core_rst_q <= 1'b0;
            end else begin
              rcnt_q <= rcnt_q + RCW'(1);
            end
          end
          S_RUN: begin
            if (timer_q != {TIMEOUT_W{1'b1}}) timer_q <= timer_q + TIMEOUT_W'(1);
            if (core_exit_i) begin
              state_q    <= S_HALT;
              result_q   <= core_dout_i;
              done_q     <= 1'b1;
              core_rst_q <= 1'b1;
            end else if (w_tmo) begin
              state_q    <= S_HALT;
              timeout_q  <= 1'b1;
              core_rst_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            core_rst_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Level interrupt, registered from enable and flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) irq_q <= 1'b0;
    else            irq_q <= irq_en_q & (done_q | timeout_q);
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign core_rst_o = core_rst_q;
  assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_leros_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leros_run_ctrl
//  Purpose  : Directed, table-driven bench for leros_run_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_leros_run_ctrl;

  localparam logic [31:0] c_BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = 32'd0, wbs_adr_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_rst_o;
  logic [31:0] core_dout_i = 32'd0;
  logic        core_exit_i = 1'b0;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  leros_run_ctrl dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .core_rst_o (core_rst_o),
    .core_dout_i(core_dout_i),
    .core_exit_i(core_exit_i),
    .irq_o      (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = 32'd0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = addr; wbs_dat_i = data; wbs_sel_i = sel;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        got = 1'b1;
        rd  = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check("wb_ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_wr(input logic [31:0] off, input logic [31:0] data);
    logic [31:0] dummy;
    wb_xfer(1'b1, c_BASE + off, data, 4'hF, dummy);
  endtask

  task automatic wb_rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, c_BASE + off, 32'd0, 4'hF, rd);
    check(name, rd, exp);
  endtask

  // Wait until the core is released; returns edges elapsed
  task automatic wait_run_start(output int edges);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk_i); #1;
      edges++;
      if (!core_rst_o) break;
    end
    check("run_started", {31'd0, core_rst_o}, 32'd0);
  endtask

  // Called while in run cycle 1; drives exit during run cycle k
  task automatic exit_at(input int k, input logic [31:0] dout);
    for (int i = 1; i < k; i++) begin
      @(posedge wb_clk_i); #1;
    end
    core_exit_i = 1'b1; core_dout_i = dout;
    @(posedge wb_clk_i); #1;
    core_exit_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk_i); #1;
    end
  endtask

  initial begin
    int edges;
    int acks;
    int run_len;
    int stuck;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 32'h04, 32'd0,          4'hF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0C, 32'd0,          4'hF, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'h08, 32'hFFFF_FFFF,  4'hF, 32'd0};
    vecs[3]  = '{1'b0, 32'h08, 32'd0,          4'hF, 32'h00FF_FFFF};
    vecs[4]  = '{1'b1, 32'h08, 32'h1234_5678,  4'h2, 32'd0};
    vecs[5]  = '{1'b0, 32'h08, 32'd0,          4'hF, 32'h00FF_56FF};
    vecs[6]  = '{1'b1, 32'h08, 32'h0000_0000,  4'hF, 32'd0};
    vecs[7]  = '{1'b0, 32'h08, 32'd0,          4'hF, 32'h0000_0000};
    vecs[8]  = '{1'b1, 32'h00, 32'h0000_0004,  4'h1, 32'd0};
    vecs[9]  = '{1'b0, 32'h00, 32'd0,          4'hF, 32'h0000_0004};
    vecs[10] = '{1'b1, 32'h00, 32'h0000_0000,  4'hE, 32'd0};
    vecs[11] = '{1'b0, 32'h00, 32'd0,          4'hF, 32'h0000_0004};
    vecs[12] = '{1'b1, 32'h00, 32'h0000_0000,  4'h1, 32'd0};
    vecs[13] = '{1'b0, 32'h00, 32'd0,          4'hF, 32'h0000_0000};
    vecs[14] = '{1'b0, 32'h10, 32'd0,          4'hF, 32'h0000_0000};
    vecs[15] = '{1'b1, 32'h18, 32'hFFFF_FFFF,  4'hF, 32'd0};
    vecs[16] = '{1'b0, 32'h18, 32'd0,          4'hF, 32'h0000_0000};
    vecs[17] = '{1'b0, 32'h24, 32'd0,          4'hF, 32'h0000_0000};

    // Reset state
    idle_cycles(3);
    check("rst_core_rst", {31'd0, core_rst_o}, 32'd1);
    check("rst_irq",      {31'd0, irq_o},      32'd0);
    check("rst_ack",      {31'd0, wbs_ack_o},  32'd0);
    check("rst_dat",      wbs_dat_o,           32'd0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    // Register map vectors
    for (int i = 0; i < 18; i++) begin
      wb_xfer(vecs[i].we, c_BASE + vecs[i].addr, vecs[i].data, vecs[i].sel, rd);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end

    // Held strobe: acked every other cycle
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = c_BASE + 32'h04; wbs_sel_i = 4'hF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("b2b_acks", 32'(acks), 32'd2);

    // Address miss never acked
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = c_BASE + 32'h100;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("miss_acks", 32'(acks), 32'd0);

    // Exit at run cycle 10, no watchdog
    wb_wr(32'h00, 32'h5);
    wait_run_start(edges);
    check("rst_hold_edges", 32'(edges), 32'd2);
    exit_at(10, 32'hCAFE_0001);
    check("exit_core_rst", {31'd0, core_rst_o}, 32'd1);
    wb_rd_check("exit_status", 32'h04, 32'h7);
    wb_rd_check("exit_result", 32'h0C, 32'hCAFE_0001);
`ifdef LEROS_CYCLE_CNT_EN
    wb_rd_check("exit_cycles10", 32'h10, 32'd10);
`endif
    check("exit_irq", {31'd0, irq_o}, 32'd1);

    // Watchdog: LIMIT=100
    wb_wr(32'h04, 32'h4);
    wb_rd_check("w1c_done", 32'h04, 32'h3);
    idle_cycles(2);
    check("w1c_irq", {31'd0, irq_o}, 32'd0);
    wb_wr(32'h08, 32'd100);
    wb_wr(32'h00, 32'h5);
    wait_run_start(edges);
    run_len = 1;
    for (int i = 0; i < 300; i++) begin
      @(posedge wb_clk_i); #1;
      if (core_rst_o) break;
      run_len++;
    end
    check("tmo_run_len", 32'(run_len), 32'd100);
    check("tmo_core_rst", {31'd0, core_rst_o}, 32'd1);
    wb_rd_check("tmo_status", 32'h04, 32'hB);
    idle_cycles(1);
    check("tmo_irq", {31'd0, irq_o}, 32'd1);
    wb_wr(32'h04, 32'h8);
    wb_rd_check("w1c_tmo", 32'h04, 32'h3);

    // Exit and timeout coincide: exit wins
    wb_wr(32'h08, 32'd5);
    wb_wr(32'h00, 32'h5);
    wait_run_start(edges);
    exit_at(5, 32'h1234_5678);
    wb_rd_check("tie_status", 32'h04, 32'h7);
    wb_rd_check("tie_result", 32'h0C, 32'h1234_5678);
    // ABORT+START in one write: abort wins, flags kept
    wb_wr(32'h00, 32'h7);
    wb_rd_check("abort_status", 32'h04, 32'h4);
    stuck = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk_i); #1;
      if (!core_rst_o) stuck++;
    end
    check("abort_no_run", 32'(stuck), 32'd0);
    // Exit ignored outside RUN
    core_exit_i = 1'b1; core_dout_i = 32'hDEAD_BEEF;
    idle_cycles(2);
    core_exit_i = 1'b0;
    wb_rd_check("idle_exit_ign", 32'h0C, 32'h1234_5678);
    wb_rd_check("idle_status", 32'h04, 32'h4);

    // Async reset mid-run
    wb_wr(32'h08, 32'd0);
    wb_wr(32'h00, 32'h5);
    wait_run_start(edges);
    idle_cycles(3);
    #2 wb_rst_ni = 1'b0;
    #1 check("arst_core_rst", {31'd0, core_rst_o}, 32'd1);
    check("arst_irq", {31'd0, irq_o}, 32'd0);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    wb_rd_check("arst_status", 32'h04, 32'h0);
    wb_rd_check("arst_result", 32'h0C, 32'h0);
    wb_rd_check("arst_ctrl",   32'h00, 32'h0);
    wb_wr(32'h00, 32'h1);
    wait_run_start(edges);
    exit_at(37, 32'h0000_0037);
    wb_rd_check("post_status", 32'h04, 32'h7);
    wb_rd_check("post_result", 32'h0C, 32'h0000_0037);
`ifdef LEROS_CYCLE_CNT_EN
    wb_rd_check("cycles37", 32'h10, 32'd37);
`else
    wb_rd_check("cycles_off", 32'h10, 32'd0);
`endif
    idle_cycles(2);
    check("post_irq_dis", {31'd0, irq_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
